vfu_vmem_responder: RTL and testbench
=====================================

Name: vfu_vmem_responder

Overview:
- Memory-side responder for the vector unit's 64-bit memory port: serves read requests and write beats issued by the vector processor inside the Vfu wrapper.
- Local single-port-equivalent scratchpad of DEPTH 64-bit words, with a fixed-latency read pipeline.
- Zero-initialises itself after reset and flags out-of-range accesses.
- Sits in the Vfu top beside rvv_proc_main and drives that processor's mem_port_in, mem_port_valid_in and mem_port_ready_out.

Parameters:
- DATA_WIDTH, 64, word width in bits; equals the processor memory data width.
- ADDR_WIDTH, 32, width of the byte address from the processor.
- DEPTH, 256, number of words; power of two, minimum 4.
- READ_LATENCY, 2, cycles from read acceptance to response; legal range 1..4.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- req_rd  in  1  read request; connects to the processor's mem_port_req.
- req_wr  in  1  write beat valid; connects to the processor's mem_port_valid_out.
- req_addr  in  ADDR_WIDTH  byte address; connects to mem_port_addr_out.
- req_wdata  in  DATA_WIDTH  write data; connects to mem_port_out.
- ready  out  1  responder can accept requests; connects to mem_port_ready_out.
- rsp_valid  out  1  read data valid, one-cycle pulse per read; connects to mem_port_valid_in.
- rsp_data  out  DATA_WIDTH  read data; connects to mem_port_in.
- err  out  1  sticky out-of-range flag.
- clear_done  out  1  post-reset initialisation complete.

Behaviour:
- Addressing:
  - Word index = req_addr[3 +: log2(DEPTH)].
  - req_addr[2:0] is ignored; accesses are word-aligned.
  - In range iff req_addr < DEPTH*8, i.e. 2048 for the defaults.
- Reset values: ready=0, rsp_valid=0, rsp_data=0, err=0, clear_done=0, read pipeline valid bits all 0, FSM=CLEAR with clear pointer 0.
- FSM CLEAR:
  - Writes 0 to word[ptr] each cycle and increments ptr.
  - After writing word DEPTH-1, moves to IDLE on the next cycle. CLEAR lasts exactly DEPTH cycles after reset deassertion.
  - ready=0 throughout; req_rd and req_wr are ignored, not queued.
- FSM IDLE:
  - ready=1 and clear_done=1 (registered; both assert on the first IDLE cycle). The FSM stays in IDLE until reset.
  - A request is accepted in any cycle where ready=1 and req_rd or req_wr is high.
- Write accepted, in range: word[idx] <= req_wdata at that clock edge.
- Read accepted, in range:
  - Array read at the acceptance edge; data enters a READ_LATENCY-deep pipeline.
  - rsp_valid=1 with rsp_data exactly READ_LATENCY cycles after the acceptance cycle.
  - Back-to-back reads, one per cycle, give back-to-back rsp_valid pulses in order. Throughput is 1 read per cycle.
  - No response backpressure exists; the processor must always accept responses.
- Simultaneous req_rd and req_wr in one cycle:
  - Both are accepted using the same address.
  - The read returns the OLD word (read-before-write); the write then commits.
- A write issued after a read is accepted does not alter that read's already-captured data.
- Out-of-range access:
  - Write is dropped.
  - Read still produces rsp_valid at the normal latency, with rsp_data=0.
  - err sets on the acceptance edge and stays set until reset.
- rsp_data holds its last value when rsp_valid=0. The bench checks it only when valid.
- Reset mid-operation:
  - In-flight reads are discarded with no rsp_valid.
  - err clears, and the FSM restarts CLEAR from ptr 0, overwriting all prior contents.
- Array is inferred as synchronous RAM; no combinational read path to rsp_data.

Test Plan:
- Reset for 2 cycles, then release -> ready=0 for exactly 256 cycles, then ready=1 and clear_done=1. A read of addr 0x7F8 returns 0x0 two cycles after acceptance.
- Write 0xDEADBEEF_01234567 to addr 0x10, then read 0x10 the next cycle -> rsp_valid exactly 2 cycles after the read acceptance, rsp_data=0xDEADBEEF_01234567. Read of 0x14 (same word) returns the same value.
- Write words at 0x00, 0x08, 0x10, 0x18 with values 1..4, then 4 back-to-back reads -> 4 consecutive rsp_valid cycles with data 1,2,3,4 in order.
- Addr 0x20 holds 0xAA; same cycle req_rd=1, req_wr=1, addr 0x20, wdata 0xBB -> response 0xAA; a subsequent read returns 0xBB.
- Write 0x55 to addr 0x800 (2048), then read 0x800 -> write dropped, rsp_valid with data 0, err=1 stays high. A read of 0x0 is unaffected.
- Issue a read, assert reset in the next cycle -> no rsp_valid appears, err=0, and ready stays low for a fresh 256 cycles. Previously written data reads back as 0.

Source files
------------

// File: rtl/vfu_vmem_if.sv
// Vector-unit memory port bundle: processor-side requests, responder-side replies.
interface vfu_vmem_if #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 32
);
  logic                  req_rd;
  logic                  req_wr;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  ready;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic                  err;
  logic                  clear_done;

  modport master (
    output req_rd, req_wr, req_addr, req_wdata,
    input  ready, rsp_valid, rsp_data, err, clear_done
  );

  modport slave (
    input  req_rd, req_wr, req_addr, req_wdata,
    output ready, rsp_valid, rsp_data, err, clear_done
  );
endinterface

// File: rtl/vfu_vmem_responder.sv
// Scratchpad responder for the vector unit memory port: self-clearing after reset,
// fixed-latency pipelined reads, word-aligned writes, sticky out-of-range flag.
module vfu_vmem_responder #(
  parameter int DATA_WIDTH   = 64,
  parameter int ADDR_WIDTH   = 32,
  parameter int DEPTH        = 256,
  parameter int READ_LATENCY = 2
) (
  input  logic       clk,
  input  logic       reset,
  vfu_vmem_if.slave  bus
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(DEPTH - 1);

  typedef enum logic {S_CLEAR, S_IDLE} state_t;

  state_t                state;
  logic [IDX_W-1:0]      ptr;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [IDX_W-1:0]      idx;
  logic                  in_range;
  logic                  acc_rd;
  logic                  acc_wr;
  logic [DATA_WIDTH-1:0] rd_word;
  logic                  unused_lsb;

  logic [READ_LATENCY:1]                 vld_pipe;
  logic [READ_LATENCY:1][DATA_WIDTH-1:0] dat_pipe;

  assign idx        = bus.req_addr[3 +: IDX_W];
  assign in_range   = (bus.req_addr[ADDR_WIDTH-1:3+IDX_W] == '0);
  assign unused_lsb = ^bus.req_addr[2:0];
  assign acc_rd     = bus.ready & bus.req_rd;
  assign acc_wr     = bus.ready & bus.req_wr;
  // Out-of-range reads still respond, with zero data.
  assign rd_word    = in_range ? mem[idx] : '0;

  assign bus.rsp_valid = vld_pipe[READ_LATENCY];
  assign bus.rsp_data  = dat_pipe[READ_LATENCY];

  // Single write port shared by the clear sweep and processor writes.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == S_CLEAR)
        mem[ptr] <= '0;
      else if (acc_wr && in_range)
        mem[idx] <= bus.req_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= S_CLEAR;
      ptr            <= '0;
      bus.ready      <= 1'b0;
      bus.clear_done <= 1'b0;
      bus.err        <= 1'b0;
    end else begin
      case (state)
        S_CLEAR: begin
          ptr <= ptr + 1'b1;
          if (ptr == LAST) begin
            state          <= S_IDLE;
            bus.ready      <= 1'b1;
            bus.clear_done <= 1'b1;
          end
        end
        default: ;
      endcase
      if ((acc_rd || acc_wr) && !in_range)
        bus.err <= 1'b1;
    end
  end

  // Data stages only advance behind a valid bit so rsp_data holds between reads.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe <= '0;
      dat_pipe <= '0;
    end else begin
      for (int k = 1; k <= READ_LATENCY; k++) begin
        if (k == 1) begin
          vld_pipe[k] <= acc_rd;
          if (acc_rd) dat_pipe[k] <= rd_word;
        end else begin
          vld_pipe[k] <= vld_pipe[k-1];
          if (vld_pipe[k-1]) dat_pipe[k] <= dat_pipe[k-1];
        end
      end
    end
  end
endmodule

// File: tb/tb_vfu_vmem_responder.sv
// Directed + random bench for vfu_vmem_responder against a cycle-counted scoreboard model.
module tb_vfu_vmem_responder;
  localparam int DW    = 64;
  localparam int AW    = 32;
  localparam int DEPTH = 256;
  localparam int LAT   = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  vfu_vmem_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) ifc ();

  vfu_vmem_responder #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .READ_LATENCY(LAT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc.slave)
  );

  typedef struct {
    int          due;
    logic [63:0] d;
  } exp_t;

  exp_t        q[$];
  logic [63:0] m_mem [DEPTH];
  logic        m_err;
  int          nrst;
  int          cyc;
  int          errors;
  int          checks;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Apply the model for the current cycle's inputs, advance one clock, check outputs.
  task automatic tick();
    bit          inr;
    int          idx;
    logic [63:0] rdat;
    if (reset) begin
      q.delete();
      m_err = 1'b0;
      nrst  = 0;
      for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    end else begin
      if (nrst >= DEPTH && (ifc.req_rd || ifc.req_wr)) begin
        inr = (ifc.req_addr < 32'(DEPTH * 8));
        idx = int'(ifc.req_addr / 8);
        if (ifc.req_rd) begin
          rdat = inr ? m_mem[idx] : 64'd0;
          q.push_back('{due: cyc + LAT, d: rdat});
        end
        if (!inr) m_err = 1'b1;
        if (ifc.req_wr && inr) m_mem[idx] = ifc.req_wdata;
      end
      if (nrst < DEPTH) nrst++;
    end
    @(posedge clk);
    #1;
    cyc++;
    chk("ready", 64'(ifc.ready), 64'(nrst >= DEPTH));
    chk("clear_done", 64'(ifc.clear_done), 64'(nrst >= DEPTH));
    chk("err", 64'(ifc.err), 64'(m_err));
    if (q.size() > 0 && q[0].due == cyc) begin
      chk("rsp_valid", 64'(ifc.rsp_valid), 64'd1);
      chk("rsp_data", ifc.rsp_data, q[0].d);
      void'(q.pop_front());
    end else begin
      chk("rsp_valid_idle", 64'(ifc.rsp_valid), 64'd0);
    end
  endtask

  task automatic drive(input bit rd, input bit wr, input logic [31:0] a, input logic [63:0] d);
    ifc.req_rd    = rd;
    ifc.req_wr    = wr;
    ifc.req_addr  = a;
    ifc.req_wdata = d;
    tick();
    ifc.req_rd = 1'b0;
    ifc.req_wr = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 32'd0, 64'd0);
  endtask

  task automatic wait_ready();
    int budget;
    budget = 0;
    while (ifc.ready !== 1'b1 && budget < DEPTH + 8) begin
      idle(1);
      budget++;
    end
    chk("ready_timeout", 64'(ifc.ready), 64'd1);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    cyc    = 0;
    nrst   = 0;
    m_err  = 1'b0;
    ifc.req_rd    = 1'b0;
    ifc.req_wr    = 1'b0;
    ifc.req_addr  = '0;
    ifc.req_wdata = '0;

    // Reset, then the clear sweep; tick() checks ready against the 256-cycle count.
    reset = 1'b1;
    idle(2);
    chk("rst_rsp_data", ifc.rsp_data, 64'd0);
    chk("rst_rsp_valid", 64'(ifc.rsp_valid), 64'd0);
    reset = 1'b0;
    wait_ready();
    drive(1'b1, 1'b0, 32'h7F8, 64'd0);
    idle(3);

    // Write then read, plus an unaligned alias of the same word.
    drive(1'b0, 1'b1, 32'h10, 64'hDEADBEEF_01234567);
    drive(1'b1, 1'b0, 32'h10, 64'd0);
    drive(1'b1, 1'b0, 32'h14, 64'd0);
    idle(3);

    // Four writes, four back-to-back reads.
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 32'(i * 8), 64'(i + 1));
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 32'(i * 8), 64'd0);
    idle(3);

    // Simultaneous read+write: read sees the old word.
    drive(1'b0, 1'b1, 32'h20, 64'hAA);
    drive(1'b1, 1'b1, 32'h20, 64'hBB);
    drive(1'b1, 1'b0, 32'h20, 64'd0);
    // A write right behind a read must not change that read's data.
    drive(1'b1, 1'b0, 32'h28, 64'd0);
    drive(1'b0, 1'b1, 32'h28, 64'h1234);
    drive(1'b1, 1'b0, 32'h28, 64'd0);
    idle(3);
    chk("bb_written", 64'(m_mem[4]), 64'hBB);

    // Randomised traffic, mostly in range.
    for (int i = 0; i < 300; i++) begin
      logic [31:0] a;
      if ($urandom_range(0, 31) == 0)
        a = 32'(DEPTH * 8) + 32'($urandom_range(0, 4095));
      else
        a = {21'd0, 8'($urandom_range(0, DEPTH - 1)), 3'($urandom)};
      drive(1'($urandom), 1'($urandom), a, {$urandom, $urandom});
    end
    idle(3);

    // Out-of-range write/read; err stays sticky; in-range reads unaffected.
    drive(1'b0, 1'b1, 32'h800, 64'h55);
    drive(1'b1, 1'b0, 32'h800, 64'd0);
    drive(1'b1, 1'b0, 32'h0, 64'd0);
    idle(4);
    chk("err_sticky", 64'(ifc.err), 64'd1);

    // Reset with a read in flight: response dropped, contents re-cleared.
    drive(1'b0, 1'b1, 32'h10, 64'hCAFE);
    drive(1'b1, 1'b0, 32'h10, 64'd0);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    chk("rst_err", 64'(ifc.err), 64'd0);
    wait_ready();
    drive(1'b1, 1'b0, 32'h10, 64'd0);
    drive(1'b1, 1'b0, 32'h20, 64'd0);
    idle(4);
    chk("queue_drained", 64'(q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
